// File: rtl/fetch_inst_queue_pkg.sv
// Shared fetch-stage types: the IF->ID payload, the NOP filler entry and the reset PC.
package cpuDefine;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam logic [31:0] NOP_INST         = 32'h03400000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } IF_DATA;

  localparam IF_DATA NOP_ENTRY = '{pc: 32'h0, inst: NOP_INST, adef: 1'b0};

endpackage

// File: rtl/fetch_inst_queue_sync_fifo.sv
// Generic synchronous FIFO with a synchronous clear; simultaneous push/pop is
// accepted at any occupancy, so a full FIFO can refill in the cycle it drains.
module sync_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = inc_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = inc_ptr(rd_ptr_q);
    end
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q    <= mem_d;
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  overflow_a: assert property (@(posedge clk) disable iff (clr) !(push && full && !pop));

endmodule

// File: rtl/fetch_inst_queue.sv
// Fetch front end: issues sequential-PC requests under a credit limit, pairs
// in-order responses with their PCs and queues entries toward decode.
module fetch_inst_queue
  import cpuDefine::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic        aclk,
  input  logic        reset,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        valid_out,
  output IF_DATA      data_out,
  input  logic        allow_in
);

  localparam int unsigned QCW = $clog2(DEPTH + 1);
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   pc_q, pc_d;
  logic          adef_lock_q, adef_lock_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;

  logic          accept, resp_keep, adef_push, fifo_clr;
  logic          q_push, q_pop, q_full, q_empty;
  IF_DATA        q_push_data, q_head;
  logic [QCW-1:0] q_count;
  logic [31:0]   tag_head;
  logic          tag_full, tag_empty;
  logic [OW-1:0] tag_count;

  always_comb begin
    req_valid = !reset && !flush && !adef_lock_q && (pc_q[1:0] == 2'b00)
             && (32'(outstanding_q) < MAX_OUTSTANDING)
             && (32'(q_count) + 32'(outstanding_q) < DEPTH);
    req_addr  = pc_q;
    accept    = req_valid && req_ready;
    fifo_clr  = reset || flush;

    // Responses owed to pre-flush requests are consumed by drop_cnt; their tags were cleared.
    resp_keep = resp_valid && (drop_cnt_q == '0) && !flush;
    adef_push = !flush && !adef_lock_q && (pc_q[1:0] != 2'b00)
             && (outstanding_q == '0) && (drop_cnt_q == '0) && !q_full && !resp_valid;

    q_push      = resp_keep || adef_push;
    q_push_data = resp_keep ? '{pc: tag_head, inst: resp_data, adef: 1'b0}
                            : '{pc: pc_q, inst: 32'h0, adef: 1'b1};
    q_pop       = !q_empty && allow_in;
    valid_out   = !q_empty;
    data_out    = q_empty ? NOP_ENTRY : q_head;

    outstanding_d = outstanding_q + OW'(accept) - OW'(resp_valid);
    drop_cnt_d    = drop_cnt_q;
    if (resp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - OW'(1);
    end
    pc_d        = accept ? pc_q + 32'd4 : pc_q;
    adef_lock_d = adef_lock_q || adef_push;

    if (flush) begin
      drop_cnt_d  = outstanding_d;
      pc_d        = flush_pc;
      adef_lock_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      adef_lock_q   <= 1'b0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      adef_lock_q   <= adef_lock_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  sync_fifo #(.T(logic [31:0]), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk      (aclk),
    .clr      (fifo_clr),
    .push     (accept),
    .push_data(pc_q),
    .pop      (resp_keep),
    .head     (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_count)
  );

  sync_fifo #(.T(IF_DATA), .DEPTH(DEPTH)) u_inst_queue (
    .clk      (aclk),
    .clr      (fifo_clr),
    .push     (q_push),
    .push_data(q_push_data),
    .pop      (q_pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  tag_track_a: assert property (@(posedge aclk) disable iff (reset)
    (32'(tag_count) <= 32'(outstanding_q)) && !(accept && tag_full) && !(resp_keep && tag_empty));

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Randomized bench for fetch_inst_queue against a transaction-level model of
// the fetch queue plus an in-order memory responder.
module tb_fetch_inst_queue;
  import cpuDefine::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 4;
  localparam logic [31:0] RPC   = 32'h1c000000;

  logic        aclk = 1'b0;
  logic        reset, req_valid, req_ready, resp_valid, flush, valid_out, allow_in;
  logic [31:0] req_addr, resp_data, flush_pc;
  IF_DATA      data_out;

  fetch_inst_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .aclk      (aclk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .valid_out (valid_out),
    .data_out  (data_out),
    .allow_in  (allow_in)
  );

  always #5 aclk = ~aclk;

  // Each accepted request: its address, earliest response cycle, and whether a flush orphaned it.
  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
    bit          dropped;
  } pend_t;

  pend_t       pend[$];
  IF_DATA      mq[$];
  logic [31:0] m_pc;
  bit          m_lock;
  int unsigned cyc = 0, total = 0, bad = 0;
  int unsigned p_ready = 100, p_allow = 100, lat_min = 1, lat_max = 1;

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
  endfunction

  task automatic step(input bit rst, input bit fl, input logic [31:0] fpc);
    bit     exp_rv, acc, adef, popq;
    IF_DATA exp_do;
    pend_t  r;
    @(negedge aclk);
    reset      = rst;
    flush      = fl;
    flush_pc   = fpc;
    req_ready  = ($urandom_range(99) < p_ready);
    allow_in   = ($urandom_range(99) < p_allow);
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    if (!rst && pend.size() > 0 && pend[0].ready <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(pend[0].addr);
    end
    #1;
    exp_rv = !rst && !fl && !m_lock && (m_pc[1:0] == 2'b00) && (pend.size() < MAXO)
          && (mq.size() + pend.size() < DEPTH);
    check_val("req_valid", req_valid, exp_rv);
    if (exp_rv) check_val("req_addr", req_addr, m_pc);
    if (!rst) begin
      exp_do = (mq.size() > 0) ? mq[0] : NOP_ENTRY;
      check_val("valid_out", valid_out, mq.size() > 0);
      check_val("data_out", data_out, exp_do);
    end

    if (rst) begin
      mq.delete();
      pend.delete();
      m_pc   = RPC;
      m_lock = 0;
    end else begin
      popq = (mq.size() > 0) && allow_in;
      acc  = exp_rv && req_ready;
      adef = !fl && !m_lock && (m_pc[1:0] != 2'b00) && (pend.size() == 0) && (mq.size() < DEPTH);
      if (popq) void'(mq.pop_front());
      if (resp_valid) begin
        r = pend.pop_front();
        if (!r.dropped && !fl) mq.push_back('{pc: r.addr, inst: resp_data, adef: 1'b0});
      end
      if (adef) begin
        mq.push_back('{pc: m_pc, inst: 32'h0, adef: 1'b1});
        m_lock = 1;
      end
      if (mq.size() > DEPTH) check_val("model_overflow", mq.size(), DEPTH);
      if (acc) begin
        pend.push_back('{addr: m_pc, ready: cyc + $urandom_range(lat_max, lat_min), dropped: 0});
        m_pc = m_pc + 32'd4;
      end
      if (fl) begin
        mq.delete();
        foreach (pend[i]) pend[i].dropped = 1;
        m_pc   = fpc;
        m_lock = 0;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] fpc;
    reset = 1'b1; flush = 1'b0; flush_pc = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; allow_in = 1'b0;
    m_pc = RPC; m_lock = 0;

    step(1, 0, 0); step(1, 0, 0);
    repeat (20) step(0, 0, 0);

    p_allow = 0;
    repeat (12) step(0, 0, 0);
    p_allow = 100;
    repeat (12) step(0, 0, 0);

    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 50; i++) begin
      if (pend.size() >= 3 && pend[0].ready <= cyc) break;
      step(0, 0, 0);
    end
    step(0, 1, 32'h1c000100);
    repeat (15) step(0, 0, 0);

    lat_min = 1; lat_max = 1;
    step(0, 1, 32'h1c000102);
    repeat (10) step(0, 0, 0);
    step(0, 1, 32'h1c000200);
    repeat (10) step(0, 0, 0);

    lat_max = 2; p_allow = 30;
    repeat (30) step(0, 0, 0);

    lat_min = 3; lat_max = 3; p_allow = 100;
    for (int i = 0; i < 50; i++) begin
      if (pend.size() >= 2) break;
      step(0, 0, 0);
    end
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);

    for (int blk = 0; blk < 10; blk++) begin
      p_ready = $urandom_range(100, 20);
      p_allow = $urandom_range(100, 10);
      lat_min = $urandom_range(2, 1);
      lat_max = lat_min + $urandom_range(3);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(199) == 0) begin
          step(1, 0, 0);
        end else if ($urandom_range(99) < 4) begin
          fpc = RPC + ($urandom_range(255) << 2);
          if ($urandom_range(9) == 0) fpc[1:0] = 2'($urandom_range(3, 1));
          step(0, 1, fpc);
        end else begin
          step(0, 0, 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
